// File: rtl/mm_result_sink_pkg.sv
// Shared definitions for the matrix-multiply result sink.
// Holds element/sum widths, dimension limits, index widths and the
// state encoding used by mm_result_sink and mm_sink_maxtrack.
package mm_result_sink_pkg;
    localparam int DW      = 20;                     // result element width (signed)
    localparam int MAX_DIM = 4;                      // max rows / cols
    localparam int IW      = $clog2(MAX_DIM);        // row/col index width
    localparam int DIMW    = $clog2(MAX_DIM + 1);    // dimension count width (0..MAX_DIM)
    localparam int SW      = DW + 4;                 // sum width: 16 full-scale elements

    localparam logic [DIMW-1:0] DIM_LIMIT = DIMW'(MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;
endpackage

// File: rtl/mm_sink_maxtrack.sv
// Running signed maximum with position.
// Ports:
//   clk, rst      clock, async active-high reset
//   init          load data at (row,col) unconditionally (first beat of a frame)
//   upd           load data at (row,col) only if strictly greater than current max
//   clr           zero the tracked value and position
//   data,row,col  candidate element and its coordinates
//   max_val, max_row, max_col   registered maximum and its position
module mm_sink_maxtrack
    import mm_result_sink_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 upd,
    input  logic                 clr,
    input  logic signed [DW-1:0] data,
    input  logic [IW-1:0]        row,
    input  logic [IW-1:0]        col,
    output logic signed [DW-1:0] max_val,
    output logic [IW-1:0]        max_row,
    output logic [IW-1:0]        max_col
);
    logic signed [DW-1:0] max_val_q, max_val_d;
    logic [IW-1:0]        max_row_q, max_row_d;
    logic [IW-1:0]        max_col_q, max_col_d;

    always_comb begin
        max_val_d = max_val_q;
        max_row_d = max_row_q;
        max_col_d = max_col_q;
        if (clr) begin
            max_val_d = '0;
            max_row_d = '0;
            max_col_d = '0;
        end else if (init || (upd && (data > max_val_q))) begin
            // strict compare: ties keep the earliest position
            max_val_d = data;
            max_row_d = row;
            max_col_d = col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val_q <= '0;
            max_row_q <= '0;
            max_col_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_row_q <= max_row_d;
            max_col_q <= max_col_d;
        end
    end

    assign max_val = max_val_q;
    assign max_row = max_row_q;
    assign max_col = max_col_q;
endmodule

// File: rtl/mm_result_sink.sv
// Result sink of the matrix-multiply engine.
// Captures one row-major result frame (row_last marks row ends), recovers
// rows/cols, flags shape errors, accumulates the element sum and tracks the
// signed maximum. The frame is held for random-access readback until clr.
// Ports:
//   clk, rst                          clock, async active-high reset
//   in_valid/in_data/in_row_last      result stream (no backpressure)
//   in_legal                          sampled on first beat; 0 = mismatch frame
//   clr                               release a DONE frame
//   rd_en/rd_row/rd_col               readback request
//   rd_data/rd_vld                    registered readback (1-cycle latency)
//   done/legal/err/rows/cols/sum/max_val/max_row/max_col   frame results
module mm_result_sink
    import mm_result_sink_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_row_last,
    input  logic                 in_legal,
    input  logic                 clr,
    input  logic                 rd_en,
    input  logic [IW-1:0]        rd_row,
    input  logic [IW-1:0]        rd_col,
    output logic signed [DW-1:0] rd_data,
    output logic                 rd_vld,
    output logic                 done,
    output logic                 legal,
    output logic                 err,
    output logic [DIMW-1:0]      rows,
    output logic [DIMW-1:0]      cols,
    output logic signed [SW-1:0] sum,
    output logic signed [DW-1:0] max_val,
    output logic [IW-1:0]        max_row,
    output logic [IW-1:0]        max_col
);
    state_e state_q, state_d;
    // Pointers run 0..MAX_DIM; a beat arriving with either at MAX_DIM overflows.
    logic [DIMW-1:0] r_q, r_d, c_q, c_d;
    logic [DIMW-1:0] rows_q, rows_d, cols_q, cols_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic legal_q, legal_d, err_q, err_d;
    logic signed [DW-1:0] rd_data_q, rd_data_d;
    logic rd_vld_q, rd_vld_d;
    logic [MAX_DIM-1:0][MAX_DIM-1:0][DW-1:0] mem_q, mem_d;

    logic mt_init, mt_upd, mt_clr;
    logic signed [SW-1:0] in_ext;

    assign in_ext = SW'(in_data);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        sum_d   = sum_q;
        legal_d = legal_q;
        err_d   = err_q;
        mem_d   = mem_q;
        mt_init = 1'b0;
        mt_upd  = 1'b0;
        mt_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    legal_d = in_legal;
                    state_d = ST_DONE;   // illegal frame: results stay zero
                    if (in_legal) begin
                        state_d     = ST_COLLECT;
                        mem_d[0][0] = in_data;
                        sum_d       = in_ext;
                        mt_init     = 1'b1;
                        if (in_row_last) begin
                            r_d    = DIMW'(1);
                            c_d    = '0;
                            cols_d = DIMW'(1);
                        end else begin
                            r_d = '0;
                            c_d = DIMW'(1);
                        end
                    end
                end
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    if (r_q == DIM_LIMIT || c_q == DIM_LIMIT) begin
                        err_d = 1'b1;    // no room: drop beat, pointers hold
                    end else begin
                        mem_d[r_q[IW-1:0]][c_q[IW-1:0]] = in_data;
                        sum_d  = sum_q + in_ext;
                        mt_upd = 1'b1;
                        if (in_row_last) begin
                            r_d = r_q + DIMW'(1);
                            c_d = '0;
                            if (r_q == '0)
                                cols_d = c_q + DIMW'(1);
                            else if ((c_q + DIMW'(1)) != cols_q)
                                err_d = 1'b1;
                        end else begin
                            c_d = c_q + DIMW'(1);
                        end
                    end
                end else begin
                    state_d = ST_DONE;
                    rows_d  = r_q;
                    if (c_q != '0) begin
                        // final row lacked row_last: count it, flag it
                        rows_d = r_q + DIMW'(1);
                        err_d  = 1'b1;
                        if (r_q == '0) cols_d = c_q;
                    end
                end
            end
            ST_DONE: begin
                if (clr) begin
                    state_d = ST_IDLE;
                    r_d     = '0;
                    c_d     = '0;
                    rows_d  = '0;
                    cols_d  = '0;
                    sum_d   = '0;
                    legal_d = 1'b0;
                    err_d   = 1'b0;
                    mem_d   = '0;
                    mt_clr  = 1'b1;
                end else if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Readback: every rd_en yields rd_vld; data is zero unless in-frame and DONE.
    always_comb begin
        rd_vld_d  = rd_en;
        rd_data_d = '0;
        if (rd_en && state_q == ST_DONE &&
            ({1'b0, rd_row} < rows_q) && ({1'b0, rd_col} < cols_q))
            rd_data_d = mem_q[rd_row][rd_col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            sum_q     <= '0;
            legal_q   <= 1'b0;
            err_q     <= 1'b0;
            mem_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            sum_q     <= sum_d;
            legal_q   <= legal_d;
            err_q     <= err_d;
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    mm_sink_maxtrack u_maxtrack (
        .clk     (clk),
        .rst     (rst),
        .init    (mt_init),
        .upd     (mt_upd),
        .clr     (mt_clr),
        .data    (in_data),
        .row     (state_q == ST_IDLE ? '0 : r_q[IW-1:0]),
        .col     (state_q == ST_IDLE ? '0 : c_q[IW-1:0]),
        .max_val (max_val),
        .max_row (max_row),
        .max_col (max_col)
    );

    assign done    = (state_q == ST_DONE);
    assign legal   = legal_q;
    assign err     = err_q;
    assign rows    = rows_q;
    assign cols    = cols_q;
    assign sum     = sum_q;
    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;
endmodule

// File: tb/tb_mm_result_sink.sv
// Directed bench for mm_result_sink. Inputs change and outputs are sampled
// on the falling edge; every task starts and ends on a falling edge.
module tb_mm_result_sink;
    logic clk = 1'b0;
    logic rst, in_valid, in_row_last, in_legal, clr, rd_en;
    logic signed [19:0] in_data;
    logic [1:0] rd_row, rd_col;
    logic signed [19:0] rd_data;
    logic rd_vld, done, legal, err;
    logic [2:0] rows, cols;
    logic signed [23:0] sum;
    logic signed [19:0] max_val;
    logic [1:0] max_row, max_col;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mm_result_sink dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_row_last(in_row_last), .in_legal(in_legal), .clr(clr),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_vld(rd_vld), .done(done), .legal(legal),
        .err(err), .rows(rows), .cols(cols), .sum(sum), .max_val(max_val),
        .max_row(max_row), .max_col(max_col)
    );

    task automatic beat(input int d, input logic last);
        in_valid = 1'b1; in_data = 20'(d); in_row_last = last; in_legal = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_frame();
        in_valid = 1'b0; in_row_last = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clr();
        in_valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_data = 0; in_row_last = 0; in_legal = 0;
        clr = 0; rd_en = 0; rd_row = 0; rd_col = 0;
        repeat (2) @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
        total++; if (sum !== 24'sd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", sum); end
        total++; if ({rows, cols, err, legal, rd_vld} !== 9'd0) begin bad++; $display("FAIL reset_flags got=%0h exp=0", {rows, cols, err, legal, rd_vld}); end
        rst = 1'b0;
        @(negedge clk);
        // readback outside DONE still returns a valid zero
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        total++; if ({rd_vld, rd_data} !== {1'b1, 20'd0}) begin bad++; $display("FAIL idle_read got=%0d/%0d exp=1/0", rd_vld, rd_data); end
    endtask

    task automatic test_basic();
        beat(1, 0);
        total++; if (sum !== 24'sd1) begin bad++; $display("FAIL basic_sum_edge1 got=%0d exp=1", sum); end
        beat(-2, 0); beat(3, 1); beat(4, 0); beat(5, 0); beat(-6, 1);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%0d exp=0", done); end
        end_frame();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0d exp=1", done); end
        total++; if (rows !== 3'd2 || cols !== 3'd3) begin bad++; $display("FAIL basic_dims got=%0dx%0d exp=2x3", rows, cols); end
        total++; if (sum !== 24'sd5) begin bad++; $display("FAIL basic_sum got=%0d exp=5", sum); end
        total++; if (max_val !== 20'sd5 || max_row !== 2'd1 || max_col !== 2'd1) begin bad++; $display("FAIL basic_max got=%0d@(%0d,%0d) exp=5@(1,1)", max_val, max_row, max_col); end
        total++; if (err !== 1'b0 || legal !== 1'b1) begin bad++; $display("FAIL basic_flags got err=%0d legal=%0d exp 0/1", err, legal); end
        rd_en = 1'b1; rd_row = 2'd1; rd_col = 2'd2;
        @(negedge clk);
        total++; if (rd_vld !== 1'b1 || rd_data !== -20'sd6) begin bad++; $display("FAIL basic_rd12 got=%0d/%0d exp=1/-6", rd_vld, rd_data); end
        rd_row = 2'd2; rd_col = 2'd0;
        @(negedge clk);
        rd_en = 1'b0;
        total++; if (rd_vld !== 1'b1 || rd_data !== 20'sd0) begin bad++; $display("FAIL basic_rd20 got=%0d/%0d exp=1/0", rd_vld, rd_data); end
        do_clr();
        total++; if (done !== 1'b0 || rows !== 3'd0 || sum !== 24'sd0 || max_val !== 20'sd0) begin bad++; $display("FAIL basic_clr got done=%0d rows=%0d sum=%0d max=%0d exp all 0", done, rows, sum, max_val); end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_data = 20'sd77; in_row_last = 1'b0; in_legal = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b1 || legal !== 1'b0) begin bad++; $display("FAIL illegal_done got done=%0d legal=%0d exp 1/0", done, legal); end
        total++; if (rows !== 3'd0 || cols !== 3'd0 || sum !== 24'sd0) begin bad++; $display("FAIL illegal_zero got %0d/%0d/%0d exp 0/0/0", rows, cols, sum); end
        beat(12, 1);
        end_frame();
        total++; if (err !== 1'b1 || sum !== 24'sd0 || rows !== 3'd0 || legal !== 1'b0) begin bad++; $display("FAIL illegal_ignore got err=%0d sum=%0d rows=%0d exp 1/0/0", err, sum, rows); end
        do_clr();
    endtask

    task automatic test_ragged();
        beat(1, 0); beat(2, 1); beat(3, 0); beat(4, 0); beat(5, 1);
        end_frame();
        total++; if (err !== 1'b1 || cols !== 3'd2 || rows !== 3'd2) begin bad++; $display("FAIL ragged got err=%0d cols=%0d rows=%0d exp 1/2/2", err, cols, rows); end
        total++; if (sum !== 24'sd15) begin bad++; $display("FAIL ragged_sum got=%0d exp=15", sum); end
        do_clr();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) beat(524287, (i % 4) == 3);
        end_frame();
        total++; if (sum !== 24'sd8388592) begin bad++; $display("FAIL full_sum got=%0d exp=8388592", sum); end
        total++; if (rows !== 3'd4 || cols !== 3'd4 || err !== 1'b0) begin bad++; $display("FAIL full_dims got=%0dx%0d err=%0d exp 4x4/0", rows, cols, err); end
        total++; if (max_val !== 20'sd524287 || max_row !== 2'd0 || max_col !== 2'd0) begin bad++; $display("FAIL full_max got=%0d@(%0d,%0d) exp=524287@(0,0)", max_val, max_row, max_col); end
        rd_en = 1'b1; rd_row = 2'd3; rd_col = 2'd3;
        @(negedge clk);
        rd_en = 1'b0;
        total++; if (rd_data !== 20'sd524287) begin bad++; $display("FAIL full_rd33 got=%0d exp=524287", rd_data); end
        do_clr();
    endtask

    task automatic test_overflow();
        beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 0); beat(100, 0);
        end_frame();
        total++; if (err !== 1'b1 || sum !== 24'sd10) begin bad++; $display("FAIL ovf got err=%0d sum=%0d exp 1/10", err, sum); end
        total++; if (rows !== 3'd1 || cols !== 3'd4) begin bad++; $display("FAIL ovf_dims got=%0dx%0d exp=1x4", rows, cols); end
        total++; if (max_val !== 20'sd4 || max_col !== 2'd3) begin bad++; $display("FAIL ovf_max got=%0d@col%0d exp=4@col3", max_val, max_col); end
        do_clr();
    endtask

    task automatic test_ties();
        beat(7, 1); beat(7, 1); beat(-1, 1); beat(7, 1);
        end_frame();
        total++; if (max_val !== 20'sd7 || max_row !== 2'd0 || max_col !== 2'd0) begin bad++; $display("FAIL tie_max got=%0d@(%0d,%0d) exp=7@(0,0)", max_val, max_row, max_col); end
        total++; if (rows !== 3'd4 || cols !== 3'd1 || sum !== 24'sd20) begin bad++; $display("FAIL tie_dims got=%0dx%0d sum=%0d exp 4x1/20", rows, cols, sum); end
        do_clr();
        beat(-5, 0); beat(-3, 0); beat(-9, 1);
        end_frame();
        total++; if (max_val !== -20'sd3 || max_row !== 2'd0 || max_col !== 2'd1) begin bad++; $display("FAIL neg_max got=%0d@(%0d,%0d) exp=-3@(0,1)", max_val, max_row, max_col); end
        total++; if (sum !== -24'sd17) begin bad++; $display("FAIL neg_sum got=%0d exp=-17", sum); end
        do_clr();
    endtask

    task automatic test_done_beat();
        beat(9, 1);
        end_frame();
        beat(50, 0);
        in_valid = 1'b0;
        total++; if (err !== 1'b1 || sum !== 24'sd9 || rows !== 3'd1 || max_val !== 20'sd9) begin bad++; $display("FAIL done_beat got err=%0d sum=%0d rows=%0d max=%0d exp 1/9/1/9", err, sum, rows, max_val); end
        in_valid = 1'b1; in_data = 20'sd33; clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        total++; if (done !== 1'b0 || err !== 1'b0 || sum !== 24'sd0) begin bad++; $display("FAIL clr_wins got done=%0d err=%0d sum=%0d exp 0/0/0", done, err, sum); end
        @(negedge clk);
        total++; if (done !== 1'b0 || sum !== 24'sd0) begin bad++; $display("FAIL clr_idle got done=%0d sum=%0d exp 0/0", done, sum); end
    endtask

    task automatic test_rst_mid();
        beat(3, 0); beat(4, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (sum !== 24'sd0 || max_val !== 20'sd0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid got sum=%0d max=%0d done=%0d exp 0/0/0", sum, max_val, done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beat(-42, 1);
        end_frame();
        total++; if (rows !== 3'd1 || cols !== 3'd1 || sum !== -24'sd42 || err !== 1'b0) begin bad++; $display("FAIL rst_new got %0dx%0d sum=%0d err=%0d exp 1x1/-42/0", rows, cols, sum, err); end
        rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
        @(negedge clk);
        rd_en = 1'b0;
        total++; if (rd_data !== -20'sd42 || max_val !== -20'sd42) begin bad++; $display("FAIL rst_new_rd got rd=%0d max=%0d exp -42/-42", rd_data, max_val); end
        do_clr();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_ragged();
        test_full();
        test_overflow();
        test_ties();
        test_done_beat();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
